param_bus_datapath: RTL and testbench

- Next-generation shared-bus datapath: NUM_REGS general registers of DATA_W bits, one accumulator (A), one result register (G) and a multi-function ALU.
- Sequenced by an internal multi-step FSM.
- Replaces fixed 16-bit/8-register datapath plus external function-code FSM.
- Instructions arrive over a valid/ready handshake; completion reported by a done pulse, carry/zero flags and an error flag.

---
 rtl/param_bus_datapath.sv | 167 ++++++++++++++++
 tb/tb_param_bus_datapath.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_bus_datapath.sv
// Shared-bus datapath: NUM_REGS general registers, accumulator A, result G and ALU, sequenced by an IDLE/T1/T2/T3 FSM.
// Optional macro DP_SATURATE_EN: ADD clamps to all-ones on carry-out, SUB clamps to zero on borrow.
module param_bus_datapath #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 8,
    localparam int RAW      = (NUM_REGS <= 2) ? 1 : $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [RAW-1:0]    rx,
    input  logic [RAW-1:0]    ry,
    input  logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic              err,
    output logic              carry,
    output logic              zero,
    output logic [DATA_W-1:0] bus_out,
    input  logic [RAW-1:0]    dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NSLOT = 1 << RAW;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

`ifdef DP_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NSLOT];
    logic [DATA_W-1:0] a_q, g_q;
    logic [2:0]        op_p0;
    logic [RAW-1:0]    rx_p0, ry_p0;
    logic [DATA_W-1:0] din_p0;
    logic              bad_p0;

    logic              legal_in, alu_in, alu_p0;
    logic [DATA_W-1:0] bus;
    logic [DATA_W:0]   add_sum;
    logic              borrow;
    logic [DATA_W-1:0] alu_res;

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] sum, input logic ovf);
        return (SAT_EN && ovf) ? '1 : sum;
    endfunction

    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] diff, input logic brw);
        return (SAT_EN && brw) ? '0 : diff;
    endfunction

    // LOAD never reads Ry, so only its destination index has to be in range
    assign legal_in = (opcode != OP_ILL) && (int'(rx) < NUM_REGS) &&
                      ((opcode == OP_LOAD) || (int'(ry) < NUM_REGS));
    assign alu_in   = opcode[2] | opcode[1];
    assign alu_p0   = op_p0[2] | op_p0[1];

    assign instr_ready = (state == IDLE);
    assign bus_out     = bus;
    assign dbg_data    = (int'(dbg_sel) < NUM_REGS) ? regs[dbg_sel] : '0;

    always_comb begin
        bus = '0;
        case (state)
            T1: begin
                if (!bad_p0) begin
                    if (op_p0 == OP_LOAD)      bus = din_p0;
                    else if (op_p0 == OP_MOVE) bus = regs[ry_p0];
                    else                       bus = regs[rx_p0];
                end
            end
            T2:      bus = regs[ry_p0];
            T3:      bus = g_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        add_sum = {1'b0, a_q} + {1'b0, bus};
        borrow  = (bus > a_q);
        case (op_p0)
            OP_ADD:  alu_res = sat_add(add_sum[DATA_W-1:0], add_sum[DATA_W]);
            OP_SUB:  alu_res = sat_sub(a_q - bus, borrow);
            OP_XOR:  alu_res = a_q ^ bus;
            OP_AND:  alu_res = a_q & bus;
            OP_OR:   alu_res = a_q | bus;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_p0  <= '0;
            rx_p0  <= '0;
            ry_p0  <= '0;
            din_p0 <= '0;
            bad_p0 <= 1'b0;
            a_q    <= '0;
            g_q    <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            for (int i = 0; i < NSLOT; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_p0  <= opcode;
                        rx_p0  <= rx;
                        ry_p0  <= ry;
                        din_p0 <= data_in;
                        bad_p0 <= !legal_in;
                        state  <= T1;
                        // single-step instructions finish in T1, so their pulse is set up now
                        if (!legal_in || !alu_in) begin
                            done <= 1'b1;
                            err  <= !legal_in;
                        end
                    end
                end
                T1: begin
                    if (bad_p0) begin
                        state <= IDLE;
                    end else if (!alu_p0) begin
                        regs[rx_p0] <= bus;
                        state       <= IDLE;
                    end else begin
                        a_q   <= bus;
                        state <= T2;
                    end
                end
                T2: begin
                    g_q <= alu_res;
                    if (op_p0 == OP_ADD)      carry <= add_sum[DATA_W];
                    else if (op_p0 == OP_SUB) carry <= borrow;
                    zero  <= (alu_res == '0);
                    done  <= 1'b1;
                    state <= T3;
                end
                T3: begin
                    regs[rx_p0] <= bus;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed bench for param_bus_datapath (NUM_REGS=6): vector table plus busy-hold and mid-instruction reset sequences.
module tb_param_bus_datapath;

    localparam int DW = 16;
    localparam int NR = 6;
    localparam int RW = 3;

`ifdef DP_SATURATE_EN
    localparam logic [15:0] R1_ADD = 16'hFFFF;
    localparam logic [15:0] R4_SUB = 16'h0000;
    localparam logic        Z_SUB  = 1'b1;
`else
    localparam logic [15:0] R1_ADD = 16'h0001;
    localparam logic [15:0] R4_SUB = 16'hFFFE;
    localparam logic        Z_SUB  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [2:0]    opcode = 3'b000;
    logic [RW-1:0] rx = '0;
    logic [RW-1:0] ry = '0;
    logic [DW-1:0] data_in = '0;
    logic          done, err, carry, zero;
    logic [DW-1:0] bus_out;
    logic [RW-1:0] dbg_sel = '0;
    logic [DW-1:0] dbg_data;

    int checks = 0;
    int failures = 0;

    param_bus_datapath #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rx(rx), .ry(ry), .data_in(data_in),
        .done(done), .err(err), .carry(carry), .zero(zero),
        .bus_out(bus_out), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [15:0] d;
        int          lat;
        logic        e;
        logic [2:0]  sel;
        logic [15:0] val;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic peek(input logic [2:0] idx, output logic [15:0] v);
        dbg_sel = idx;
        #1;
        v = dbg_data;
    endtask

    // Ends one cycle after done (or after the cycle budget), 1 time unit past a rising edge.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                             input logic [15:0] d, output int lat, output logic e);
        @(posedge clk); #1;
        opcode = op; rx = x; ry = y; data_in = d; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        opcode = 3'b111; rx = x ^ 3'b001; ry = y ^ 3'b001; data_in = 16'hDEAD;
        lat = 0;
        e = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (done) begin
                lat = c;
                e = err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        e;
        logic [15:0] v;
        int          done_seen;

        vecs[0]  = '{3'd0, 3'd3, 3'd0, 16'h1234, 1, 1'b0, 3'd3, 16'h1234, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 3'd1, 3'd0, 16'hFFFF, 1, 1'b0, 3'd1, 16'hFFFF, 1'b0, 1'b0};
        vecs[2]  = '{3'd0, 3'd2, 3'd0, 16'h0002, 1, 1'b0, 3'd2, 16'h0002, 1'b0, 1'b0};
        vecs[3]  = '{3'd2, 3'd1, 3'd2, 16'h0000, 3, 1'b0, 3'd1, R1_ADD,   1'b1, 1'b0};
        vecs[4]  = '{3'd0, 3'd4, 3'd0, 16'h0005, 1, 1'b0, 3'd4, 16'h0005, 1'b1, 1'b0};
        vecs[5]  = '{3'd0, 3'd5, 3'd0, 16'h0007, 1, 1'b0, 3'd5, 16'h0007, 1'b1, 1'b0};
        vecs[6]  = '{3'd3, 3'd4, 3'd5, 16'h0000, 3, 1'b0, 3'd4, R4_SUB,   1'b1, Z_SUB};
        vecs[7]  = '{3'd4, 3'd4, 3'd4, 16'h0000, 3, 1'b0, 3'd4, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{3'd0, 3'd0, 3'd0, 16'hF0F0, 1, 1'b0, 3'd0, 16'hF0F0, 1'b1, 1'b1};
        vecs[9]  = '{3'd5, 3'd0, 3'd3, 16'h0000, 3, 1'b0, 3'd0, 16'h1030, 1'b1, 1'b0};
        vecs[10] = '{3'd6, 3'd2, 3'd3, 16'h0000, 3, 1'b0, 3'd2, 16'h1236, 1'b1, 1'b0};
        vecs[11] = '{3'd2, 3'd2, 3'd2, 16'h0000, 3, 1'b0, 3'd2, 16'h246C, 1'b0, 1'b0};
        vecs[12] = '{3'd3, 3'd2, 3'd2, 16'h0000, 3, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b1};
        vecs[13] = '{3'd1, 3'd5, 3'd3, 16'h0000, 1, 1'b0, 3'd5, 16'h1234, 1'b0, 1'b1};
        vecs[14] = '{3'd7, 3'd1, 3'd2, 16'h0000, 1, 1'b1, 3'd1, R1_ADD,   1'b0, 1'b1};
        vecs[15] = '{3'd0, 3'd7, 3'd0, 16'hBEEF, 1, 1'b1, 3'd1, R1_ADD,   1'b0, 1'b1};
        vecs[16] = '{3'd2, 3'd1, 3'd6, 16'h0000, 1, 1'b1, 3'd1, R1_ADD,   1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_carry", carry, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_bus", bus_out, 16'h0);
        for (int r = 0; r < NR; r++) begin
            peek(3'(r), v);
            chk($sformatf("rst_r%0d", r), v, 16'h0);
        end

        for (int i = 0; i < 17; i++) begin
            run_instr(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].d, lat, e);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_err", i), e, vecs[i].e);
            chk($sformatf("v%0d_done_clr", i), done, 1'b0);
            chk($sformatf("v%0d_ready", i), instr_ready, 1'b1);
            chk($sformatf("v%0d_bus_idle", i), bus_out, 16'h0);
            chk($sformatf("v%0d_carry", i), carry, vecs[i].c);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
            peek(vecs[i].sel, v);
            chk($sformatf("v%0d_reg", i), v, vecs[i].val);
            if (i == 0) begin
                for (int r = 0; r < NR; r++) begin
                    if (r != 3) begin
                        peek(3'(r), v);
                        chk($sformatf("v0_other_r%0d", r), v, 16'h0);
                    end
                end
            end
        end
        peek(3'd7, v);
        chk("dbg_out_of_range", v, 16'h0);

        // Busy hold: operands change while an ADD runs; only the ADD executes.
        run_instr(3'd0, 3'd1, 3'd0, 16'h0010, lat, e);
        run_instr(3'd0, 3'd2, 3'd0, 16'h0003, lat, e);
        @(posedge clk); #1;
        opcode = 3'd2; rx = 3'd1; ry = 3'd2; instr_valid = 1'b1;
        @(posedge clk); #1;
        chk("busy_t1_ready", instr_ready, 1'b0);
        chk("busy_t1_bus", bus_out, 16'h0010);
        opcode = 3'd0; rx = 3'd1; ry = 3'd0; data_in = 16'hBEEF;
        @(posedge clk); #1;
        chk("busy_t2_ready", instr_ready, 1'b0);
        chk("busy_t2_bus", bus_out, 16'h0003);
        chk("busy_t2_done", done, 1'b0);
        @(posedge clk); #1;
        chk("busy_t3_ready", instr_ready, 1'b0);
        chk("busy_t3_done", done, 1'b1);
        chk("busy_t3_bus", bus_out, 16'h0013);
        @(posedge clk); #1;
        chk("busy_idle_ready", instr_ready, 1'b1);
        chk("busy_carry", carry, 1'b0);
        chk("busy_zero", zero, 1'b0);
        peek(3'd1, v);
        chk("busy_add_r1", v, 16'h0013);
        @(posedge clk); #1;
        chk("busy_next_done", done, 1'b1);
        chk("busy_next_err", err, 1'b0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        peek(3'd1, v);
        chk("busy_next_r1", v, 16'hBEEF);

        // Reset dropped during T2 of an ADD.
        run_instr(3'd0, 3'd2, 3'd0, 16'hFFFF, lat, e);
        @(posedge clk); #1;
        opcode = 3'd2; rx = 3'd1; ry = 3'd2; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_carry", carry, 1'b0);
        chk("mid_rst_zero", zero, 1'b0);
        chk("mid_rst_bus", bus_out, 16'h0);
        for (int r = 0; r < NR; r++) begin
            peek(3'(r), v);
            chk($sformatf("mid_rst_r%0d", r), v, 16'h0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("mid_rst_no_done", done_seen, 0);
        chk("mid_rst_ready", instr_ready, 1'b1);
        run_instr(3'd0, 3'd2, 3'd0, 16'h00AA, lat, e);
        chk("post_rst_lat", lat, 1);
        peek(3'd2, v);
        chk("post_rst_r2", v, 16'h00AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
